// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that shares the 8:1 gate-level mux between eight requesters.
// It drives the mux selects with the granted index and forces a rotation when one owner holds the mux too long.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       valid,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       owner;
    logic [7:0]       others;
    logic [3:0]       pick_any;
    logic [3:0]       pick_oth;
    logic             limit;
    logic             load;
    logic             rotate;
    logic             go_idle;
    logic [2:0]       load_idx;

    // Returns {found, index} of the first set bit at or after p, wrapping mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign owner    = {s2, s1, s0};
    assign others   = req & ~(8'b0000_0001 << owner);
    assign pick_any = rr_pick(req, ptr);
    assign pick_oth = rr_pick(others, ptr);
    assign limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // A release takes priority over a limit hit, so timeout only fires while the owner still requests.
    always_comb begin
        load     = 1'b0;
        rotate   = 1'b0;
        go_idle  = 1'b0;
        load_idx = pick_any[2:0];
        if (state == IDLE) begin
            load = pick_any[3];
        end else if (!req[owner]) begin
            load    = pick_any[3];
            go_idle = !pick_any[3];
        end else if (limit && pick_oth[3]) begin
            load     = 1'b1;
            rotate   = 1'b1;
            load_idx = pick_oth[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            grant    <= 8'h00;
            valid    <= 1'b0;
            {s2, s1, s0} <= 3'b000;
            timeout  <= 1'b0;
        end else begin
            timeout <= rotate;
            if (load) begin
                state        <= GRANT;
                grant        <= 8'b0000_0001 << load_idx;
                valid        <= 1'b1;
                {s2, s1, s0} <= load_idx;
                ptr          <= load_idx + 3'd1;
                hold_cnt     <= '0;
            end else if (go_idle) begin
                state    <= IDLE;
                grant    <= 8'h00;
                valid    <= 1'b0;
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= limit ? '0 : hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random requests against a behavioural model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       valid, s0, s1, s2, timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_hold = 0;
    int         m_sel = 0;
    logic       m_to = 1'b0;
    logic [7:0] e_grant;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .valid(valid),
        .s0(s0), .s1(s1), .s2(s2), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_next(input logic [7:0] r, input int p, input int excl);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (p + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic take(input int n);
        m_owner = n;
        m_ptr   = (n + 1) % 8;
        m_hold  = 0;
        m_sel   = n;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic rn);
        int n;
        if (!rn) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                n = find_next(r, m_ptr, -1);
                if (n >= 0) take(n);
            end else if (!r[m_owner]) begin
                n = find_next(r, m_ptr, -1);
                if (n >= 0) take(n);
                else begin m_owner = -1; m_hold = 0; end
            end else if (m_hold == MAX_HOLD - 1) begin
                n = find_next(r, m_ptr, m_owner);
                if (n >= 0) begin take(n); m_to = 1'b1; end
                else m_hold = 0;
            end else begin
                m_hold++;
            end
        end
        e_grant = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    endtask

    // One clock: drive at negedge, update model at posedge, compare just after.
    task automatic step(input logic [7:0] r, input logic rn);
        @(negedge clk);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        model_edge(r, rn);
        #1;
        chk("grant", {24'd0, grant}, {24'd0, e_grant});
        chk("valid", {31'd0, valid}, {31'd0, (m_owner >= 0)});
        chk("sel", {29'd0, s2, s1, s0}, 32'(m_sel));
        chk("timeout", {31'd0, timeout}, {31'd0, m_to});
    endtask

    initial begin
        logic [7:0] r;

        // Reset with everything requesting
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        chk("rst_grant", {24'd0, grant}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        step(8'hFF, 1'b1);
        chk("first_grant", {24'd0, grant}, 32'h01);

        // Round robin: each owner releases after three cycles of grant
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1);
            step(8'hFF, 1'b1);
            step(8'hFF & ~e_grant, 1'b1);
            chk("rr_seq", {24'd0, grant}, 32'(1 << ((i + 1) % 8)));
            chk("rr_valid", {31'd0, valid}, 32'd1);
        end

        // Single requester never times out
        step(8'h00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(8'h20, 1'b1);
            chk("single_grant", {24'd0, grant}, 32'h20);
            chk("single_to", {31'd0, timeout}, 32'd0);
        end

        // Forced rotation between requesters 0 and 3
        step(8'h00, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            step(8'h09, 1'b1);
            chk("rot_grant", {24'd0, grant}, (i <= 16 || i == 33) ? 32'h01 : 32'h08);
            chk("rot_to", {31'd0, timeout}, (i == 17 || i == 33) ? 32'd1 : 32'd0);
        end

        // Release coinciding with the limit is a plain release
        step(8'h00, 1'b0);
        for (int i = 1; i <= 16; i++) step(8'h44, 1'b1);
        chk("lim_hold", {24'd0, grant}, 32'h04);
        step(8'h40, 1'b1);
        chk("lim_grant", {24'd0, grant}, 32'h40);
        chk("lim_sel", {29'd0, s2, s1, s0}, 32'd6);
        chk("lim_to", {31'd0, timeout}, 32'd0);

        // Mid-grant reset clears the pointer
        step(8'h00, 1'b0);
        step(8'h10, 1'b1);
        step(8'h10, 1'b1);
        chk("mid_pre", {24'd0, grant}, 32'h10);
        step(8'h90, 1'b0);
        chk("mid_rst", {24'd0, grant}, 32'h00);
        step(8'h90, 1'b1);
        chk("mid_post", {24'd0, grant}, 32'h10);

        // Random traffic with sticky requests so hold limits are reached
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 8'($urandom);
            if ($urandom_range(0, 15) == 0 && m_owner >= 0) r[m_owner] = 1'b0;
            step(r, ($urandom_range(0, 199) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
